fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 24 ++
 rtl/fifo_wr_arbiter_if.sv | 36 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 40 ++++
 rtl/fifo_wr_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_e : arbiter state (IDLE = no lock, BURST = one requester locked)
//   idx_width() : bit width of a requester index
//   cnt_width() : bit width of the per-burst beat counter
package fifo_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned NUM_REQ_MIN   = 2;
  localparam int unsigned NUM_REQ_MAX   = 8;
  localparam int unsigned MAX_BURST_MAX = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_burst);
    return $clog2(max_burst) + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of requester handshakes and FIFO write-port signals.
//   req_valid/req_data/req_last : requester beats (requester i at bits [i*DATA_SIZE +: DATA_SIZE])
//   req_ready                   : per-requester accept
//   wfull                       : FIFO full flag (wr_clk domain)
//   wr_en/wr_data               : FIFO write port
//   grant_id/busy               : current or most recent owner, burst lock held
// Modports: master = requesters + FIFO side, slave = arbiter.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8
);
  localparam int unsigned IW = idx_width(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         wfull;
  logic                         wr_en;
  logic [DATA_SIZE-1:0]         wr_data;
  logic [IW-1:0]                grant_id;
  logic                         busy;

  modport master (
    output req_valid, req_data, req_last, wfull,
    input  req_ready, wr_en, wr_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, wfull,
    output req_ready, wr_en, wr_data, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of i_valid scanning upward
// from i_ptr, wrapping NUM_REQ-1 to 0.
//   i_valid     : request vector
//   i_ptr       : scan start index (must be < NUM_REQ)
//   o_winner    : winning index (i_ptr when nothing is valid)
//   o_any_valid : at least one request present
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IW-1:0]      i_ptr,
  output logic [IW-1:0]      o_winner,
  output logic               o_any_valid
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [IW:0]          w_sum;
  logic                 w_found;

  // Doubling the vector and shifting by the pointer turns the wrapped scan
  // into a plain lowest-set-bit search over NUM_REQ bits.
  always_comb begin
    w_dbl   = {i_valid, i_valid} >> i_ptr;
    w_found = 1'b0;
    w_sum   = {1'b0, i_ptr};
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!w_found && w_dbl[j]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, i_ptr} + (IW+1)'(j);
      end
    end
    o_any_valid = w_found;
    o_winner    = (w_sum >= (IW+1)'(NUM_REQ)) ? IW'(w_sum - (IW+1)'(NUM_REQ))
                                              : IW'(w_sum);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates NUM_REQ requesters onto one FIFO write port. Round-robin in IDLE;
// a multi-beat packet locks its requester for up to MAX_BURST beats.
//   wr_clk  : FIFO write clock, rising edge
//   wr_rstn : asynchronous active-low reset
//   bus     : fifo_wr_arbiter_if.slave (requester beats, FIFO write port, status)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic            wr_clk,
  input  logic            wr_rstn,
  fifo_wr_arbiter_if.slave bus
);

  localparam int unsigned   IW       = idx_width(NUM_REQ);
  localparam int unsigned   CW       = cnt_width(MAX_BURST);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_e     r_state;
  logic [IW-1:0]  r_rr_ptr;
  logic [IW-1:0]  r_lock;
  logic [IW-1:0]  r_grant;
  logic [CW-1:0]  r_beat_cnt;

  logic [IW-1:0]        w_winner;
  logic                 w_any_valid;
  logic [IW-1:0]        w_sel;
  logic                 w_sel_valid;
  logic                 w_sel_last;
  logic [DATA_SIZE-1:0] w_sel_data;
  logic                 w_busy;
  logic                 w_offer;
  logic                 w_accept;
  logic [IW-1:0]        w_grant;
  logic [NUM_REQ-1:0]   w_ready;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_valid     (bus.req_valid),
    .i_ptr       (r_rr_ptr),
    .o_winner    (w_winner),
    .o_any_valid (w_any_valid)
  );

  assign w_busy = (r_state == ST_BURST);
  assign w_sel  = w_busy ? r_lock : w_winner;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_sel == IW'(i)) begin
        w_sel_valid = bus.req_valid[i];
        w_sel_last  = bus.req_last[i];
        w_sel_data  = bus.req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // The locked requester keeps its ready while it stalls its own valid;
  // in IDLE ready is offered only when there is a winner to offer it to.
  assign w_offer  = wr_rstn & ~bus.wfull & (w_busy | w_any_valid);
  assign w_accept = wr_rstn & ~bus.wfull & w_sel_valid;

  always_comb begin
    w_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_ready[i] = w_offer & (w_sel == IW'(i));
    end
  end

  // grant_id tracks the live selection during a transfer or lock and
  // otherwise shows the registered previous owner.
  assign w_grant = (w_busy | w_accept) ? w_sel : r_grant;

  assign bus.req_ready = w_ready;
  assign bus.wr_en     = w_accept;
  assign bus.wr_data   = wr_rstn ? w_sel_data : '0;
  assign bus.grant_id  = w_grant;
  assign bus.busy      = w_busy;

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_lock     <= '0;
      r_beat_cnt <= '0;
      r_grant    <= '0;
    end else begin
      r_grant <= w_grant;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_sel_last || (MAX_BURST == 1)) begin
              r_rr_ptr <= next_idx(w_sel);
            end else begin
              r_state    <= ST_BURST;
              r_lock     <= w_sel;
              r_beat_cnt <= CW'(1);
            end
          end
        end
        ST_BURST: begin
          if (w_accept) begin
            if (w_sel_last || (r_beat_cnt == CNT_LAST)) begin
              r_state    <= ST_IDLE;
              r_rr_ptr   <= next_idx(r_lock);
              r_beat_cnt <= '0;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_SIZE=8, MAX_BURST=4).
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned DS = 8;
  localparam int unsigned MB = 4;

  logic wr_clk = 1'b0;
  logic wr_rstn;
  int   n_cmp = 0;
  int   n_bad = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_SIZE(DS)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_SIZE (DS),
    .MAX_BURST (MB)
  ) dut (
    .wr_clk  (wr_clk),
    .wr_rstn (wr_rstn),
    .bus     (bus)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l,
                       input logic [31:0] d, input logic wf);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
    bus.wfull     = wf;
  endtask

  // Check one cycle's outputs, then advance past the next rising edge.
  task automatic expect_cycle(input string tag, input logic we, input logic [7:0] wd,
                              input logic [3:0] rdy, input logic [1:0] gid, input logic bsy);
    @(negedge wr_clk);
    check_eq({tag, " wr_en"},     bus.wr_en,     we);
    check_eq({tag, " req_ready"}, bus.req_ready, rdy);
    check_eq({tag, " grant_id"},  bus.grant_id,  gid);
    check_eq({tag, " busy"},      bus.busy,      bsy);
    if (we) check_eq({tag, " wr_data"}, bus.wr_data, wd);
    tick();
  endtask

  task automatic do_reset();
    wr_rstn = 1'b0;
    drive(4'h0, 4'h0, 32'h0, 1'b0);
    tick();
    tick();
    wr_rstn = 1'b1;
  endtask

  logic [1:0] rr_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  // Burst-split vectors: req1 six-beat packet, req2 single beats throughout.
  logic [7:0] b_d1  [7] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h15, 8'h16};
  logic       b_l1  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [1:0] b_g   [7] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1};
  logic       b_bsy [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] b_wd  [7] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h20, 8'h15, 8'h16};

  // Stall vectors: req0 burst with wfull high for three cycles.
  logic       s_wf  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] s_d0  [7] = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03, 8'h04};
  logic       s_bsy [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  int writes;
  int accepts;

  initial begin
    wr_rstn = 1'b0;
    drive(4'hF, 4'hF, 32'hA3A2A1A0, 1'b0);

    // Reset state: everything quiet even with all requesters valid.
    @(negedge wr_clk);
    check_eq("rst wr_en",     bus.wr_en,     1'b0);
    check_eq("rst req_ready", bus.req_ready, 4'h0);
    check_eq("rst wr_data",   bus.wr_data,   8'h00);
    check_eq("rst grant_id",  bus.grant_id,  2'd0);
    check_eq("rst busy",      bus.busy,      1'b0);
    tick();
    wr_rstn = 1'b1;

    // Round-robin with single-beat packets.
    for (int unsigned k = 0; k < 5; k++) begin
      expect_cycle($sformatf("rr%0d", k), 1'b1, 8'hA0 + 8'(rr_order[k]),
                   4'h1 << rr_order[k], rr_order[k], 1'b0);
    end

    // Long packet is split at MAX_BURST; req2 gets a turn in between.
    do_reset();
    for (int unsigned k = 0; k < 7; k++) begin
      drive(4'b0110, {1'b0, 1'b1, b_l1[k], 1'b0}, {8'h00, 8'h20, b_d1[k], 8'h00}, 1'b0);
      expect_cycle($sformatf("burst%0d", k), 1'b1, b_wd[k], 4'h1 << b_g[k], b_g[k], b_bsy[k]);
    end
    drive(4'h0, 4'h0, 32'h0, 1'b0);
    expect_cycle("burst_end", 1'b0, 8'h00, 4'h0, 2'd1, 1'b0);

    // wfull stalls a held burst.
    do_reset();
    for (int unsigned k = 0; k < 7; k++) begin
      drive(4'b0001, 4'b0000, {24'h0, s_d0[k]}, s_wf[k]);
      expect_cycle($sformatf("stall%0d", k), !s_wf[k], s_d0[k],
                   s_wf[k] ? 4'h0 : 4'h1, 2'd0, s_bsy[k]);
    end
    drive(4'h0, 4'h0, 32'h0, 1'b0);
    expect_cycle("stall_end", 1'b0, 8'h00, 4'h0, 2'd0, 1'b0);

    // Locked requester drops valid; req0 must wait for req3's last beat.
    do_reset();
    drive(4'b1000, 4'b0000, 32'h31000000, 1'b0);
    expect_cycle("lock0", 1'b1, 8'h31, 4'b1000, 2'd3, 1'b0);
    drive(4'b0001, 4'b0001, 32'h00000005, 1'b0);
    expect_cycle("lock1", 1'b0, 8'h00, 4'b1000, 2'd3, 1'b1);
    expect_cycle("lock2", 1'b0, 8'h00, 4'b1000, 2'd3, 1'b1);
    drive(4'b1001, 4'b1001, 32'h32000005, 1'b0);
    expect_cycle("lock3", 1'b1, 8'h32, 4'b1000, 2'd3, 1'b1);
    drive(4'b0001, 4'b0001, 32'h00000005, 1'b0);
    expect_cycle("lock4", 1'b1, 8'h05, 4'b0001, 2'd0, 1'b0);

    // Reset mid-burst drops the lock; arbitration restarts at req0.
    do_reset();
    drive(4'b0100, 4'b0000, 32'h00410000, 1'b0);
    expect_cycle("mrst0", 1'b1, 8'h41, 4'b0100, 2'd2, 1'b0);
    drive(4'b0100, 4'b0000, 32'h00420000, 1'b0);
    expect_cycle("mrst1", 1'b1, 8'h42, 4'b0100, 2'd2, 1'b1);
    wr_rstn = 1'b0;
    drive(4'b0101, 4'b0101, 32'h00430007, 1'b0);
    for (int unsigned k = 0; k < 2; k++) begin
      @(negedge wr_clk);
      check_eq("mrst busy",      bus.busy,      1'b0);
      check_eq("mrst wr_en",     bus.wr_en,     1'b0);
      check_eq("mrst req_ready", bus.req_ready, 4'h0);
      check_eq("mrst wr_data",   bus.wr_data,   8'h00);
      tick();
    end
    wr_rstn = 1'b1;
    expect_cycle("mrst_rel", 1'b1, 8'h07, 4'b0001, 2'd0, 1'b0);

    // wfull toggling every cycle: one write per non-full cycle.
    do_reset();
    writes  = 0;
    accepts = 0;
    for (int unsigned k = 0; k < 8; k++) begin
      drive(4'b0010, 4'b0010, {16'h0, 8'h50 + 8'(k), 8'h0}, k[0]);
      @(negedge wr_clk);
      if (bus.wr_en) writes++;
      if (bus.req_ready[1] && bus.req_valid[1]) accepts++;
      check_eq($sformatf("tog%0d wr_en", k), bus.wr_en, !k[0]);
      if (!k[0]) check_eq($sformatf("tog%0d wr_data", k), bus.wr_data, 8'h50 + 8'(k));
      tick();
    end
    check_eq("tog writes",  writes,  4);
    check_eq("tog accepts", accepts, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
